// File: rtl/piece_randomizer.sv
// piece_randomizer: bag-shuffled piece generator (Galois LFSR) feeding a FIFO with a preview window.
// Optional hold slot: define PIECE_HOLD_EN.
module piece_randomizer #(
   parameter int          NUM_TYPES = 7,
   parameter int          TYPE_W    = 3,
   parameter int          DEPTH     = 14,
   parameter int          PREVIEW   = 3,
   parameter int          MAX_TRIES = 8,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       pop,
   input  logic                       reseed,
   input  logic [15:0]                seed_in,
`ifdef PIECE_HOLD_EN
   input  logic                       hold_req,
   output logic                       held_valid,
   output logic [TYPE_W-1:0]          held_piece,
`endif
   output logic                       next_valid,
   output logic [TYPE_W-1:0]          next_piece,
   output logic [PREVIEW*TYPE_W-1:0]  preview,
   output logic [PREVIEW-1:0]         preview_valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       bag_done
);
   localparam int CW    = $clog2(DEPTH+1);
   localparam int TRW   = $clog2(MAX_TRIES+1);
   localparam int NCAND = 2**TYPE_W;

   typedef enum logic {GEN, FULL} state_t;
   state_t state, state_nxt;

   logic [15:0]          lfsr, lfsr_step;
   logic [TYPE_W-1:0]    fifo [DEPTH];
   logic [NUM_TYPES-1:0] used, used_set, used_nxt;
   logic [NCAND-1:0]     used_pad;
   logic [TRW-1:0]       tries, tries_nxt;
   logic [TYPE_W-1:0]    cand, fallback, push_val;
   logic [CW-1:0]        wr_idx;
   logic                 push, do_pop, accept, found, bag_wrap;

   assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign cand      = lfsr[TYPE_W-1:0];
   assign used_pad  = NCAND'(used);
   assign accept    = (32'(cand) < 32'(NUM_TYPES)) && !used_pad[cand];
   assign next_valid = (count != '0);

   always_comb begin
      fallback = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < NUM_TYPES; i++) begin
         if (!used[i] && !found) begin
            fallback = TYPE_W'(i);
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_val  = cand;
      tries_nxt = tries;
      case (state)
         GEN: begin
            if (count == CW'(DEPTH)) begin
               state_nxt = FULL;
            end else if (accept) begin
               push      = 1'b1;
               tries_nxt = '0;
            end else if (tries == TRW'(MAX_TRIES-1)) begin
               push      = 1'b1;
               push_val  = fallback;
               tries_nxt = '0;
            end else begin
               tries_nxt = tries + 1'b1;
            end
         end
         FULL: if (count != CW'(DEPTH)) state_nxt = GEN;
         default: state_nxt = GEN;
      endcase
   end

   assign used_set = used | (NUM_TYPES'(1) << push_val);
   assign bag_wrap = push && (&used_set);
   assign used_nxt = push ? (bag_wrap ? '0 : used_set) : used;

`ifdef PIECE_HOLD_EN
   logic hold_go, hold_take, hold_swap;
   assign hold_go   = hold_req && next_valid;
   assign hold_take = hold_go && !held_valid;
   assign hold_swap = hold_go && held_valid;
   assign do_pop    = next_valid && (hold_go ? hold_take : pop);
`else
   assign do_pop    = pop && next_valid;
`endif

   // Shift-down FIFO: head is always fifo[0] and unoccupied slots stay zero.
   assign wr_idx = do_pop ? count - 1'b1 : count;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state    <= GEN;
         lfsr     <= SEED;
         count    <= '0;
         used     <= '0;
         tries    <= '0;
         bag_done <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
`ifdef PIECE_HOLD_EN
         held_valid <= 1'b0;
         held_piece <= '0;
`endif
      end else if (reseed) begin
         state    <= GEN;
         lfsr     <= (seed_in == 16'h0000) ? SEED : seed_in;
         count    <= '0;
         used     <= '0;
         tries    <= '0;
         bag_done <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
`ifdef PIECE_HOLD_EN
         held_valid <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         lfsr     <= lfsr_step;
         tries    <= tries_nxt;
         used     <= used_nxt;
         bag_done <= bag_wrap;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (do_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo[i] <= fifo[i+1];
            fifo[DEPTH-1] <= '0;
         end
         if (push) fifo[wr_idx] <= push_val;
`ifdef PIECE_HOLD_EN
         if (hold_take) begin
            held_valid <= 1'b1;
            held_piece <= fifo[0];
         end
         if (hold_swap) begin
            fifo[0]    <= held_piece;
            held_piece <= fifo[0];
         end
`endif
      end
   end

   assign next_piece = fifo[0];

   always_comb begin
      preview       = '0;
      preview_valid = '0;
      for (int unsigned i = 0; i < PREVIEW; i++) begin
         preview[i*TYPE_W +: TYPE_W] = fifo[i];
         preview_valid[i]            = (count > CW'(i));
      end
   end
endmodule
